// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_t;

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit ripple-carry slice assembled from per-bit full adders.
module nibble_adder_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice over NIB cycles, LS nibble first,
// with valid/ready handshakes on operands and result.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_reg;
  logic [CNT_W-1:0] nib_cnt;
  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout;

  nibble_adder_slice u_slice (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)            state_nxt = S_RUN;
      S_RUN:   if (nib_cnt == LAST_NIB) state_nxt = S_DONE;
      S_DONE:  if (out_ready)           state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs come from state alone; rst masks in_ready so no
  // operand is offered while the block is being cleared.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign out_sum   = sum_sh;
  assign out_cout  = carry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_sh    <= '0;
      carry_reg <= 1'b0;
      nib_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          carry_reg <= in_cin;
          nib_cnt   <= '0;
        end
        S_RUN: begin
          sum_sh    <= (sum_sh >> NIB_W) | (WIDTH'(slice_sum) << (WIDTH - NIB_W));
          carry_reg <= slice_cout;
          nib_cnt   <= nib_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand shifters carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      a_sh <= in_a;
      b_sh <= in_b;
    end else if (state == S_RUN) begin
      a_sh <= a_sh >> NIB_W;
      b_sh <= b_sh >> NIB_W;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH=16 and WIDTH=4 against an arithmetic model.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [15:0] in_a, in_b, out_sum;
  logic        v4, r4, cin4, ov4, or4, co4, busy4;
  logic [3:0]  a4, b4, s4;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
    .in_a(a4), .in_b(b4), .in_cin(cin4), .out_valid(ov4),
    .out_ready(or4), .out_sum(s4), .out_cout(co4), .busy(busy4)
  );

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 5'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation on the 16-bit DUT and reports latency and result.
  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input bit release_out, output int lat,
                          output logic [15:0] s, output logic co);
    int guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    tick();
    in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) lat = -1;
    s = out_sum; co = out_cout;
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    v4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (out_sum !== 16'h0) begin n_err++; $display("FAIL reset_out_sum got=%h want=0000", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_err++; $display("FAIL reset_out_cout got=%b want=0", out_cout); end
    n_cmp++; if (busy !== 1'b0 || busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b/%b want=0/0", busy, busy4); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || r4 !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got=%b/%b want=1/1", in_ready, r4); end
  endtask

  task automatic test_directed();
    logic [15:0] ta[4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    logic [15:0] tb[4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001};
    logic        tc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] es[4] = '{16'h5555, 16'h0000, 16'h0000, 16'h8000};
    logic        ec[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat; logic [15:0] s; logic co;
    for (int i = 0; i < 4; i++) begin
      run_op16(ta[i], tb[i], tc[i], 1'b1, lat, s, co);
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL dir%0d_latency got=%0d want=4", i, lat); end
      n_cmp++; if (s !== es[i]) begin n_err++; $display("FAIL dir%0d_sum got=%h want=%h", i, s, es[i]); end
      n_cmp++; if (co !== ec[i]) begin n_err++; $display("FAIL dir%0d_cout got=%b want=%b", i, co, ec[i]); end
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_return_idle got=%b%b want=10", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] s; logic co;
    run_op16(16'h1111, 16'h2222, 1'b1, 1'b0, lat, s, co);
    n_cmp++; if (s !== 16'h3334 || co !== 1'b0) begin n_err++; $display("FAIL bp_result got=%b_%h want=0_3334", co, s); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_sum !== 16'h3334 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b sum=%h c=%b rdy=%b want v=1 sum=3334 c=0 rdy=0",
                 i, out_valid, out_sum, out_cout, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release got v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
    run_op16(16'h0F0F, 16'h0101, 1'b0, 1'b1, lat, s, co);
    n_cmp++; if (s !== 16'h1010 || co !== 1'b0 || lat != 4) begin n_err++; $display("FAIL bp_next got=%b_%h lat=%0d want=0_1010 lat=4", co, s, lat); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [15:0] s; logic co; bit saw_valid = 0;
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_in_reset got rdy=%b v=%b busy=%b want 0 0 0", in_ready, out_valid, busy); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready_after got=%b want=1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) saw_valid = 1;
      tick();
    end
    n_cmp++; if (saw_valid) begin n_err++; $display("FAIL abort_no_valid got=1 want=0"); end
    run_op16(16'h00FF, 16'h0001, 1'b0, 1'b1, lat, s, co);
    n_cmp++; if (s !== 16'h0100 || co !== 1'b0 || lat != 4) begin n_err++; $display("FAIL abort_next got=%b_%h lat=%0d want=0_0100 lat=4", co, s, lat); end
  endtask

  task automatic test_back_to_back16();
    logic [16:0] q[$];
    logic [16:0] exp;
    int last = -1;
    int results = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : 17'h1XXXX;
        n_cmp++; if ({out_cout, out_sum} !== exp) begin n_err++; $display("FAIL b2b16_result%0d got=%h want=%h", results, {out_cout, out_sum}, exp); end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != 6) begin n_err++; $display("FAIL b2b16_interval got=%0d want=6", cyc - last); end
        end
        last = cyc; results++;
      end
      in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      if (in_ready) q.push_back(ref16(in_a, in_b, in_cin));
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (results != 10 || q.size() != 0) begin n_err++; $display("FAIL b2b16_count got=%0d left=%0d want=10 left=0", results, q.size()); end
  endtask

  task automatic test_back_to_back4();
    logic [4:0] q[$];
    logic [4:0] exp;
    int last = -1;
    int results = 0;
    v4 = 1'b1; or4 = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (ov4) begin
        exp = (q.size() > 0) ? q.pop_front() : 5'b1XXXX;
        n_cmp++; if ({co4, s4} !== exp) begin n_err++; $display("FAIL b2b4_result%0d got=%h want=%h", results, {co4, s4}, exp); end
        if (results == 0) begin
          n_cmp++; if ({co4, s4} !== 5'h10) begin n_err++; $display("FAIL b2b4_F_plus_1 got=%h want=10", {co4, s4}); end
        end
        if (last >= 0) begin
          n_cmp++; if (cyc - last != 3) begin n_err++; $display("FAIL b2b4_interval got=%0d want=3", cyc - last); end
        end
        last = cyc; results++;
      end
      if (cyc == 0) begin
        a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      end
      if (r4) q.push_back(ref4(a4, b4, cin4));
      tick();
    end
    v4 = 1'b0;
    tick();
    or4 = 1'b0;
    n_cmp++; if (results != 10 || q.size() != 0) begin n_err++; $display("FAIL b2b4_count got=%0d left=%0d want=10 left=0", results, q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_back_to_back16();
    test_back_to_back4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
